// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the instruction fetch path.
//   RESET_PC_DEFAULT : fetch address loaded at reset unless overridden
//   NOP_INSTR        : instruction presented while no instruction is valid
//   fetch_state_t    : fetch controller states
//   word_align()     : force a byte address onto a 32-bit word boundary
`timescale 1ns/1ps
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {pc, instruction} pairs.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_data at the tail
//   i_pop       : drop the head entry (caller only pops when non-empty)
//   i_flush     : discard all entries; overrides push and pop
//   o_head      : head entry, valid while o_empty is low
//   o_empty     : no entries stored
//   o_count     : current occupancy
`timescale 1ns/1ps
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible after it was written.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end between the instruction memory
// and the control unit. Issues word-aligned sequential fetches, buffers the
// returned words with their addresses, and restarts at a new address on
// redirect, discarding responses still in flight for the old path.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr: fetch request channel
//   imem_rsp_valid, imem_rdata     : in-order read responses (latency >= 1)
//   instr_valid/ready, instr, instr_pc : instruction stream to control unit
//   redirect, redirect_target      : taken branch / jump
//   perf_fetched, perf_stall       : only with FETCH_PERF_CNT_EN defined
// Parameters: RESET_PC (reset fetch address), BUF_DEPTH (2 or 4).
// Optional feature macro: FETCH_PERF_CNT_EN adds wrapping performance
// counters; without it the ports and counters do not exist.
`timescale 1ns/1ps
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t  r_state;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic [CW-1:0] w_occupancy;
  logic [CW:0]   w_inflight;
  logic          w_empty;
  logic [63:0]   w_head;
  logic          w_req_fire;
  logic          w_rsp_live;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_stale;
  logic [31:0]   w_rsp_pc;

  // A request is only issued when a buffer slot is reserved for its
  // response, so the FIFO can never overflow. rst_n gates the request
  // directly so it drops the moment reset is asserted.
  assign w_inflight     = {1'b0, w_occupancy} + {1'b0, r_outstanding};
  assign imem_req_valid = rst_n && (r_state == FETCH) && !redirect &&
                          (w_inflight < (CW + 1)'(BUF_DEPTH));
  assign imem_addr      = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response only belongs to the current path in FETCH with a request
  // still owed; anything else (e.g. left over from before a reset) is dropped.
  assign w_rsp_live = imem_rsp_valid && (r_state == FETCH) && (r_outstanding != '0);
  assign w_push     = w_rsp_live && !redirect;
  assign w_pop      = instr_valid && instr_ready;

  // Responses return in order, so the oldest owed request sits
  // r_outstanding words behind the next fetch address.
  assign w_rsp_pc = r_fetch_pc - 32'({r_outstanding, 2'b00});

  // Requests still owed after a redirect, excluding one answered this cycle.
  assign w_stale = r_outstanding - CW'(w_rsp_live);

  // state | meaning
  // FETCH | normal issue; live responses are buffered
  // DRAIN | no issue; responses for the pre-redirect path are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (redirect) begin
            r_fetch_pc    <= word_align(redirect_target);
            r_outstanding <= '0;
            r_discard     <= w_stale;
            if (w_stale != '0) r_state <= DRAIN;
          end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_live);
          end
        end
        DRAIN: begin
          if (redirect) r_fetch_pc <= word_align(redirect_target);
          if (imem_rsp_valid) begin
            r_discard <= r_discard - 1'b1;
            if (r_discard == CW'(1)) r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({w_rsp_pc, imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_occupancy)
  );

  assign instr_valid = !w_empty;
  assign instr       = instr_valid ? w_head[31:0]  : NOP_INSTR;
  assign instr_pc    = instr_valid ? w_head[63:32] : 32'h0000_0000;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (w_pop) perf_fetched <= perf_fetched + 32'd1;
      if (instr_ready && !instr_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_target;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall      (perf_stall)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: a bijective scramble of the word address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h0000_0001;
  endfunction

  // ---------------- memory model ----------------
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc       = 0;
  bit          mem_hold  = 1'b0;
  bit          mem_ready = 1'b1;
  int          mem_lat   = 1;
  int          n_rsp     = 0;
  int          n_acc     = 0;
  int          n_pop     = 0;

  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = 32'h0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      imem_req_ready = mem_ready;
      if (!mem_hold && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rdata     = mem_data(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
        n_rsp++;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
      end
    end
  end

  // ---------------- stream model + per-cycle compare ----------------
  logic [31:0] exp_pc, exp_req;
  bit          p_iv_hold, p_rv_hold;
  logic [31:0] p_instr, p_pc, p_addr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] m_fetched, m_stall;
`endif

  initial begin
    p_iv_hold = 1'b0;
    p_rv_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_iv_hold = 1'b0;
        p_rv_hold = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        m_fetched = 32'd0;
        m_stall   = 32'd0;
`endif
        continue;
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall", perf_stall, m_stall);
      if (instr_valid && instr_ready) m_fetched++;
      if (instr_ready && !instr_valid) m_stall++;
`endif
      if (p_iv_hold) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_instr", instr, p_instr);
        chk("hold_pc", instr_pc, p_pc);
      end
      if (p_rv_hold && imem_req_valid) chk("hold_addr", imem_addr, p_addr);
      if (!instr_valid) chk("nop_when_idle", instr, NOP_INSTR);
      if (redirect) chk("no_req_on_redirect", imem_req_valid, 0);
      if (instr_valid && instr_ready) begin
        chk("pop_pc", instr_pc, exp_pc);
        chk("pop_instr", instr, mem_data(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_pop++;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_addr, exp_req);
        exp_req = exp_req + 32'd4;
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + mem_lat);
        n_acc++;
      end
      chk("inflight_le_depth", (mq_addr.size() <= DEPTH) ? 1 : 0, 1);
      if (redirect) begin
        exp_pc  = {redirect_target[31:2], 2'b00};
        exp_req = {redirect_target[31:2], 2'b00};
      end
      p_iv_hold = instr_valid && !instr_ready && !redirect;
      p_rv_hold = imem_req_valid && !imem_req_ready;
      p_instr   = instr;
      p_pc      = instr_pc;
      p_addr    = imem_addr;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_accept(input string name, output logic [31:0] addr);
    bit ok = 1'b0;
    addr = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (imem_req_valid && imem_req_ready) begin
        ok = 1'b1;
        addr = imem_addr;
        break;
      end
    end
    chk({name, "_accept_seen"}, ok, 1);
  endtask

  task automatic wait_outstanding2(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (mq_addr.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_two_outstanding"}, ok, 1);
  endtask

  task automatic drive_cycle();
    @(posedge clk); #2;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] a;
  int          cnt0, cnt1;
  bit          found;
  bit [15:0]   rpat, ipat;

  initial begin
    rst_n           = 1'b0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    exp_pc          = RPC;
    exp_req         = RPC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_nop", instr, NOP_INSTR);

    // Reset release, ready=1, latency 1.
    @(posedge clk); #3;
    instr_ready = 1'b1;
    rst_n       = 1'b1;
    @(negedge clk);
    chk("c0_req_valid", imem_req_valid, 1);
    chk("c0_addr", imem_addr, RPC);
    chk("c0_instr_valid", instr_valid, 0);
    @(negedge clk);
    chk("c1_req_valid", imem_req_valid, 1);
    chk("c1_addr", imem_addr, RPC + 32'd4);
    chk("c1_instr_valid", instr_valid, 0);
    @(negedge clk);
    chk("c2_instr_valid", instr_valid, 1);
    chk("c2_instr_pc", instr_pc, RPC);
    chk("c2_instr", instr, mem_data(RPC));
    repeat (8) drive_cycle();

    // Consumer stall for 10 cycles.
    instr_ready = 1'b0;
    cnt0 = n_acc;
    repeat (10) @(negedge clk);
    #1;
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_instr_valid", instr_valid, 1);
    chk("stall_mem_idle", mq_addr.size(), 0);
    chk("stall_accepts_le_depth", ((n_acc - cnt0) <= DEPTH) ? 1 : 0, 1);
    drive_cycle();
    instr_ready = 1'b1;
    cnt1 = n_pop;
    repeat (10) drive_cycle();
    chk("stall_release_pops", ((n_pop - cnt1) >= DEPTH) ? 1 : 0, 1);

    // Irregular memory ready / consumer ready, then latency 2.
    rpat = 16'b1011_0010_1110_0100;
    ipat = 16'b1101_1010_0111_0011;
    for (int i = 0; i < 16; i++) begin
      drive_cycle();
      mem_ready   = rpat[i];
      instr_ready = ipat[i];
    end
    mem_ready   = 1'b1;
    instr_ready = 1'b1;
    mem_lat     = 2;
    repeat (12) drive_cycle();

    // Redirect to 0x102 with two requests outstanding.
    mem_lat  = 1;
    mem_hold = 1'b1;
    wait_outstanding2("redir102");
    drive_cycle();
    redirect        = 1'b1;
    redirect_target = 32'h0000_0102;
    drive_cycle();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_no_req", imem_req_valid, 0);
      chk("drain_instr_valid", instr_valid, 0);
    end
    drive_cycle();
    cnt0     = n_rsp;
    mem_hold = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (imem_req_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("drain_exit_seen", found, 1);
    chk("drain_exit_addr", imem_addr, 32'h0000_0100);
    chk("drain_stale_count", n_rsp - cnt0, 2);
    chk("drain_nothing_buffered", instr_valid, 0);
    repeat (8) drive_cycle();

    // Redirect coinciding with a response and a pop.
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle();
      if (imem_rsp_valid && instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("coincide_found", found, 1);
    redirect        = 1'b1;
    redirect_target = 32'h0000_2000;
    @(negedge clk);
    chk("coincide_rsp_valid", imem_rsp_valid, 1);
    chk("coincide_pop", instr_valid && instr_ready, 1);
    drive_cycle();
    redirect = 1'b0;
    @(negedge clk);
    chk("coincide_flushed", instr_valid, 0);
    chk("coincide_next_req", imem_req_valid, 1);
    chk("coincide_next_addr", imem_addr, 32'h0000_2000);
    repeat (8) drive_cycle();

    // Address wrap at the top of the address space.
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFF9;
    drive_cycle();
    redirect = 1'b0;
    wait_accept("wrap0", a);
    chk("wrap_addr0", a, 32'hFFFF_FFF8);
    wait_accept("wrap1", a);
    chk("wrap_addr1", a, 32'hFFFF_FFFC);
    wait_accept("wrap2", a);
    chk("wrap_addr2", a, 32'h0000_0000);
    wait_accept("wrap3", a);
    chk("wrap_addr3", a, 32'h0000_0004);
    repeat (8) drive_cycle();

    // Reset asserted in the middle of DRAIN.
    mem_hold = 1'b1;
    wait_outstanding2("rstdrain");
    drive_cycle();
    redirect        = 1'b1;
    redirect_target = 32'h0000_0300;
    drive_cycle();
    redirect = 1'b0;
    @(negedge clk);
    chk("pre_rst_draining", imem_req_valid, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    mem_hold = 1'b0;
    #1;
    chk("midrst_req_valid", imem_req_valid, 0);
    chk("midrst_instr_valid", instr_valid, 0);
    chk("midrst_instr_nop", instr, NOP_INSTR);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_perf_fetched", perf_fetched, 0);
    chk("midrst_perf_stall", perf_stall, 0);
`endif
    @(posedge clk); #3;
    exp_pc  = RPC;
    exp_req = RPC;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("restart_req_valid", imem_req_valid, 1);
    chk("restart_addr", imem_addr, RPC);
    repeat (12) drive_cycle();
    @(negedge clk);
    chk("restart_progress", (n_pop > 0) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
